// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial addition controller. This block sequences one external 1-bit full
// adder so that two WIDTH-bit operands are added LSB first, one bit per clock.
// It holds the operand shift registers, the carry flip-flop, the bit counter
// and the start/done handshake. The full adder is outside this block.
//
// Optional feature: define SERIAL_ADDER_OVF_EN to add the ovf output. ovf is
// the signed two's-complement overflow flag.
//
// Parameters:
//   WIDTH    operand/result width in bits (2..32)
//
// Ports:
//   clk      clock. All state changes on the rising edge.
//   rst      asynchronous, active-high reset
//   start    request. Sampled only while IDLE.
//   a, b     operands, captured on the accepting edge
//   cin      initial carry, captured on the accepting edge
//   busy     high while in RUN or DONE
//   done     one-cycle pulse when sum/cout are valid
//   sum      result. Held from done until the next accepted start.
//   cout     final carry. Same validity as sum.
//   fa_s1    to the adder: current A bit (0 outside RUN)
//   fa_s0    to the adder: current B bit (0 outside RUN)
//   fa_cin   to the adder: carry flip-flop (0 outside RUN)
//   fa_sum   from the adder: sum bit
//   fa_cout  from the adder: carry out
//   ovf      (SERIAL_ADDER_OVF_EN only) signed overflow, valid with sum
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_s1,
  output logic             fa_s0,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             carry_reg, carry_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             last_bit;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_reg, ovf_next;
`endif

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_reg   <= ovf_next;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sum_next   = sum_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_next   = ovf_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = a;
          b_next     = b;
          carry_next = cin;
          cnt_next   = '0;
          state_next = RUN;
        end
      end

      RUN: begin
        a_next     = {1'b0, a_reg[WIDTH-1:1]};
        b_next     = {1'b0, b_reg[WIDTH-1:1]};
        sum_next   = {fa_sum, sum_reg[WIDTH-1:1]};
        carry_next = fa_cout;
        if (last_bit) begin
          // The counter holds on the final bit. For power-of-two WIDTH,
          // incrementing here would wrap the counter to zero.
          state_next = DONE;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_reg is the carry into the MSB. fa_cout is the carry out of it.
          ovf_next   = carry_reg ^ fa_cout;
`endif
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from registers only. There is no combinational path
  // from the inputs.
  assign busy   = (state_reg == RUN) || (state_reg == DONE);
  assign done   = (state_reg == DONE);
  assign sum    = sum_reg;
  assign cout   = carry_reg;
  assign fa_s1  = (state_reg == RUN) & a_reg[0];
  assign fa_s0  = (state_reg == RUN) & b_reg[0];
  assign fa_cin = (state_reg == RUN) & carry_reg;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf    = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Self-checking bench for serial_adder_ctrl with WIDTH=8. The external 1-bit
// full adder is modelled here with continuous assignments. A table of
// directed vectors is applied and checked in a loop. Separate hand-written
// sequences cover these cases:
//   - operands and start changing during RUN
//   - reset in the middle of an operation
//   - start held high continuously
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         fa_s1;
  logic         fa_s0;
  logic         fa_cin;
  logic         fa_sum;
  logic         fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .fa_s1   (fa_s1),
    .fa_s0   (fa_s0),
    .fa_cin  (fa_cin),
    .fa_sum  (fa_sum),
    .fa_cout (fa_cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  // External full adder
  assign fa_sum  = fa_s1 ^ fa_s0 ^ fa_cin;
  assign fa_cout = (fa_s1 & fa_s0) | (fa_s1 & fa_cin) | (fa_s0 & fa_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait for the next rising edge, then step 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one addition, starting from an IDLE cycle (posedge+1).
  // When scramble=1, a, b and start are randomised on every busy cycle.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vcin,
                        input logic [W-1:0] esum, input logic ecout, input logic eovf,
                        input bit scramble);
    logic c;
    logic nc;
    a     = va;
    b     = vb;
    cin   = vcin;
    start = 1'b1;
    tick();                        // E0: the accepting edge
    start = 1'b0;
    check("busy_after_E0", busy, 1);
    c = vcin;
    for (int i = 0; i < W; i++) begin
      check("fa_s1_run", fa_s1, va[i]);
      check("fa_s0_run", fa_s0, vb[i]);
      check("fa_cin_run", fa_cin, c);
      check("done_early", done, 0);
      check("busy_run", busy, 1);
      nc = (va[i] & vb[i]) | (va[i] & c) | (vb[i] & c);
      c  = nc;
      if (scramble) begin
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
      end
      tick();                      // edges E1..E(W)
    end
    // DONE cycle
    check("done_pulse", done, 1);
    check("busy_done", busy, 1);
    check("sum", sum, esum);
    check("cout", cout, ecout);
    check("fa_zero_done", {fa_s1, fa_s0, fa_cin}, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf", ovf, eovf);
`endif
    if (scramble) start = 1'b1;    // ignored in DONE
    tick();                        // DONE -> IDLE
    start = 1'b0;
    check("done_width", done, 0);
    check("busy_idle", busy, 0);
    check("sum_hold", sum, esum);
    check("cout_hold", cout, ecout);
    check("fa_zero_idle", {fa_s1, fa_s0, fa_cin}, 0);
    $display("op a=0x%02h b=0x%02h cin=%0d -> sum=0x%02h cout=%0d (exp 0x%02h %0d)%s",
             va, vb, vcin, sum, cout, esum, ecout, scramble ? " scrambled" : "");
  endtask

  initial begin
    int last_done;
    int pulses;
    int first_done;

    vecs[0] = '{a: 8'h3C, b: 8'h45, cin: 1'b0, sum: 8'h81, cout: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 8'h10, b: 8'h20, cin: 1'b0, sum: 8'h30, cout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
    vecs[6] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0, ovf: 1'b0};
    vecs[7] = '{a: 8'hA5, b: 8'h5A, cin: 1'b0, sum: 8'hFF, cout: 1'b0, ovf: 1'b0};

    // Reset state
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_fa", {fa_s1, fa_s0, fa_cin}, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    tick();

    // Table-driven vectors
    for (int v = 0; v < 8; v++)
      run_op(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].sum, vecs[v].cout, vecs[v].ovf, 1'b0);

    // Operands and start change during RUN. The result must still follow the
    // operands captured at E0.
    run_op(8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1);
    tick();
    check("scramble_no_restart", busy, 0);

    // Reset in the 4th RUN cycle
    a = 8'h3C; b = 8'h45; cin = 1'b0; start = 1'b1;
    tick();                        // E0
    start = 1'b0;
    tick(); tick(); tick();        // now in the 4th RUN cycle
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_done", done, 0);
    check("abort_fa", {fa_s1, fa_s0, fa_cin}, 0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    $display("reset abort: busy=%0d sum=0x%02h done pulses after abort=%0d", busy, sum, pulses);
    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);

    // start held high continuously: done every W+2 cycles
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    last_done  = -1;
    first_done = -1;
    pulses     = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        pulses++;
        check("stream_sum", sum, 8'h02);
        if (last_done >= 0) check("stream_period", k - last_done, W + 2);
        else first_done = k;
        last_done = k;
      end
    end
    start = 1'b0;
    check("stream_first_latency", first_done, W + 1);
    check("stream_pulses", pulses, 4);
    $display("stream: %0d done pulses, first at cycle %0d", pulses, first_done);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that sequences one external `full_adder_1bit` instance to add two WIDTH-bit operands, LSB first, one bit per clock. It owns the operand shift registers, the carry flip-flop, the bit counter and the start/done handshake. The adder itself stays outside; this block drives its inputs and samples its outputs.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- cin  in  1  initial carry; captured on the accepting edge.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  WIDTH  result; held stable from done until the next accepted start.
- cout  out  1  final carry; same validity as sum.
- fa_s1  out  1  to adder s1, the current A bit.
- fa_s0  out  1  to adder s0, the current B bit.
- fa_cin  out  1  to adder cin, the carry flip-flop.
- fa_sum  in  1  from adder sum.
- fa_cout  in  1  from adder cout.

## Operation
- State machine states: IDLE, RUN, DONE.
- IDLE with start=1: load the a and b shift registers, load the carry flip-flop with cin, clear the counter, go to RUN. With start=0, stay in IDLE.
- RUN, on each edge:
  - Shift the A and B registers right by one bit.
  - Shift fa_sum into the MSB of the sum register.
  - Load fa_cout into the carry flip-flop.
  - Increment the counter.
  - When the counter equals WIDTH-1, go to DONE.
- DONE: done=1 and cout equals the carry flip-flop. Go to IDLE on the next edge unconditionally.
- fa_s1, fa_s0 and fa_cin are driven by registers only (A LSB, B LSB, carry), so there is no combinational path from the inputs.
- fa_s1, fa_s0 and fa_cin are forced to 0 outside RUN.
- start in RUN or DONE is ignored and never queued. It must be re-asserted in IDLE to be accepted.
- Arithmetic is unsigned modulo 2^WIDTH, with the carry reported on cout. The counter is clog2(WIDTH) bits wide and never wraps within an operation.
- Reset puts the machine in IDLE and clears all registers: sum=0, cout=0, busy=0, done=0, and fa_* = 0.
- Reset asserted mid-operation aborts the operation. No done pulse is produced and the partial sum is discarded.

## Timing
- The accepting edge is E0. RUN covers edges E1..E(WIDTH). done is high in the cycle after E(WIDTH), for exactly 1 cycle.
- Start-to-done latency: WIDTH+1 cycles. The next start can be accepted at the edge that ends the first IDLE cycle after DONE.
- Throughput: one addition per WIDTH+2 cycles when start is held high continuously.
- busy rises in the cycle after E0 and falls in the cycle after DONE.
- sum and cout remain valid after done until the edge that accepts the next start, then read as in progress.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Adds output port ovf (1 bit), the signed two's-complement overflow: carry into the MSB XOR final carry out.
  - The carry into the MSB is captured during the last RUN cycle.
  - ovf is valid with sum and cleared by reset.
- SERIAL_ADDER_OVF_EN undefined: the ovf port and its flip-flop do not exist. All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x3C, b=0x45, cin=0, start for 1 cycle -> done pulses exactly 9 cycles after the accepting edge; sum=0x81, cout=0; ovf=1 when OVF_EN is defined.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Change a, b and start every cycle during RUN -> the result still reflects the operands captured at E0; no second operation starts until IDLE.
- Assert rst in the 4th RUN cycle -> busy=0, sum=0, cout=0, and no done pulse. A fresh start with 0x10+0x20 then gives sum=0x30.
- Hold start=1 continuously with a=0x01, b=0x01 -> done pulses every 10 cycles, sum=0x02 each time.
- Compare fa_s1, fa_s0 and fa_cin each RUN cycle against the operand bits and the expected carry chain; all three must be 0 in IDLE and DONE.
